serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor. Computes diff = a - b - bin over WIDTH bits.
- Processes DIGIT bits per cycle through a ripple chain of full-subtractor cells, with a borrow register chaining the digits.
- Valid/ready on both sides. Used where a full-width combinational subtractor is too large or too slow.
- Also reports borrow-out, signed overflow and a zero flag.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  difference a - b - bin, modulo 2^WIDTH.
- bout  out  1  borrow-out: 1 iff a < b + bin (unsigned).
- ovf  out  1  signed overflow of a - b - bin (two's complement).
- zero  out  1  diff == 0.

Behaviour:
- Reset (async assert, synchronous release on clk): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, zero=0. Internal shift registers, borrow register and counter are cleared.
- N = WIDTH/DIGIT steps.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge: capture a, b into shift registers; load borrow_reg=bin; capture a[WIDTH-1] and b[WIDTH-1]; cnt=0; go to BUSY.
  - BUSY: in_ready=0. Each edge:
    - Feed the low DIGIT bits of the a/b shift registers plus borrow_reg through the digit chain.
    - Shift the DIGIT result bits into the top of the result register (LSB digit first, so after N steps the result is aligned).
    - borrow_reg = chain borrow-out; cnt++.
    - On the edge where cnt == N-1: go to DONE, register bout = final borrow, set out_valid=1.
  - DONE: out_valid=1. diff, bout, ovf and zero are stable and held until out_ready=1 at an edge; then out_valid=0 and state goes to IDLE. in_ready=0 while in DONE.
- Latency: operands accepted at edge k -> out_valid high after edge k+N.
- Throughput: one operation per N+2 cycles when the consumer is always ready. No overlap between operations.
- Flag definitions:
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb), using the captured MSBs.
  - zero = ~|diff.
  - Both are registered together with out_valid.
- Full-subtractor cell: d = x^y^bi; bo = (~x&y) | (~x&bi) | (y&bi).
- Input changes in BUSY or DONE are ignored. in_valid held high while busy is not accepted twice.
- out_ready asserted in IDLE or BUSY has no effect.
- DIGIT == WIDTH: N=1; result is ready one cycle after acceptance.
- Reset asserted in any state aborts the operation immediately; outputs return to their reset values. No partial result is ever presented.

Decomposition:
- Package serial_subtractor_pkg: state enum {IDLE, BUSY, DONE}; function computing N = WIDTH/DIGIT; counter width = $clog2(N)+1.
- Sub-module fs_digit (parameter DIGIT): purely combinational ripple of DIGIT full-subtractor cells. Ports x[DIGIT], y[DIGIT], bi -> d[DIGIT], bo.
- Top instantiates fs_digit once.
- Elaboration-time check that WIDTH % DIGIT == 0.

Test Plan:
- WIDTH=16, DIGIT=4, out_ready=1: a=0x1234, b=0x0234, bin=0 -> out_valid 4 cycles after accept; diff=0x1000, bout=0, ovf=0, zero=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, zero=0.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1; then a=0x0005, b=0x0004, bin=1 -> diff=0x0000, zero=1, bout=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> diff and flags stable, in_ready=0 throughout. A new in_valid with a=0x0001 is not accepted until one cycle after out_ready=1.
- Reset mid-op: assert rst_n=0 at cycle 2 of BUSY -> out_valid=0, diff=0 immediately; in_ready=1 after release; the next op a=0x00FF, b=0x000F yields 0x00F0.
- Random regression across DIGIT in {1,2,4,8,16}, 1000 ops each, compared against {bout,diff} = {1'b0,a} - b - bin.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_steps(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fs_digit.sv
// Combinational ripple of DIGIT full-subtractor cells, LSB cell first.
module fs_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  always_comb begin
    logic br;
    d  = '0;
    br = bi;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~x[i] & br) | (y[i] & br);
    end
    bo = br;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - bin: accept in IDLE, WIDTH/DIGIT cycles in BUSY, hold result in DONE.
// Result and flags stay stable while out_ready is low; no new operands are taken until the result drains.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = num_steps(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow_reg;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] chain_d;
  logic             chain_bo;
  logic             last_step;

  fs_digit #(.DIGIT(DIGIT)) u_fs_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .bi (borrow_reg),
    .d  (chain_d),
    .bo (chain_bo)
  );

  assign last_step = (cnt == CW'(N - 1));
  // New digit enters at the top so the first (LSB) digit ends at bit 0 after N steps.
  assign res_nxt   = (res >> DIGIT) | (WIDTH'(chain_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      borrow_reg <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      bout       <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= a;
            b_sh       <= b;
            res        <= '0;
            borrow_reg <= bin;
            a_msb      <= a[WIDTH-1];
            b_msb      <= b[WIDTH-1];
            cnt        <= '0;
          end
        end
        BUSY: begin
          a_sh       <= a_sh >> DIGIT;
          b_sh       <= b_sh >> DIGIT;
          res        <= res_nxt;
          borrow_reg <= chain_bo;
          cnt        <= cnt + CW'(1);
          // Outputs only change here, so nothing partial is ever visible.
          if (last_step) begin
            diff <= res_nxt;
            bout <= chain_bo;
            zero <= ~|res_nxt;
            ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
